// File: rtl/spi_minion_if.sv
// Bundles the SPI pins and both val/rdy message channels of spi_minion.
// Ports: spi_ifc_cs/sclk/mosi/miso (SPI pins), recv_* (core -> MISO words),
//        send_* (MOSI words -> core), overflow/underflow (status pulses).
// The slave modport is the minion's view; the master modport is the core/master side.
interface spi_minion_if #(
  parameter int nbits = 34
);
  logic             spi_ifc_cs;
  logic             spi_ifc_sclk;
  logic             spi_ifc_mosi;
  logic             spi_ifc_miso;
  logic             recv_val;
  logic             recv_rdy;
  logic [nbits-1:0] recv_msg;
  logic             send_val;
  logic             send_rdy;
  logic [nbits-1:0] send_msg;
  logic             overflow;
  logic             underflow;

  modport slave (
    input  spi_ifc_cs, spi_ifc_sclk, spi_ifc_mosi, recv_val, recv_msg, send_rdy,
    output spi_ifc_miso, recv_rdy, send_val, send_msg, overflow, underflow
  );

  modport master (
    output spi_ifc_cs, spi_ifc_sclk, spi_ifc_mosi, recv_val, recv_msg, send_rdy,
    input  spi_ifc_miso, recv_rdy, send_val, send_msg, overflow, underflow
  );
endinterface

// File: rtl/spi_minion.sv
// SPI mode-0 minion: deserialises MOSI into nbits-wide words for the core and
// serialises core words onto MISO; one word of buffering in each direction.
// Ports: clk, reset (async, active high), ifc (spi_minion_if.slave: SPI pins,
//        recv_* TX word input, send_* RX word output, overflow/underflow pulses).
// All SPI pins are asynchronous to clk: pin-to-event latency is 3 clk, so the
// master must run sclk at most clk/8 and wait >= 4 clk from CS low to first rise.
module spi_minion #(
  parameter int nbits    = 34,
  parameter int logBitsN = $clog2(nbits) + 1
) (
  input logic         clk,
  input logic         reset,
  spi_minion_if.slave ifc
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state;
  // [0],[1]: two-flop synchroniser; [2]: delay flop for edge detection
  logic [2:0]          cs_sync;
  logic [2:0]          sclk_sync;
  logic [2:0]          mosi_sync;
  logic                cs_fall;
  logic                cs_rise;
  logic                sclk_rise;
  logic                sclk_fall;
  logic [nbits-1:0]    tx_buf;
  logic                tx_buf_val;
  logic [nbits-1:0]    tx_shift;
  logic [nbits-1:0]    rx_shift;
  logic [logBitsN-1:0] bit_cnt;

  assign cs_fall   = ~cs_sync[1] &  cs_sync[2];
  assign cs_rise   =  cs_sync[1] & ~cs_sync[2];
  assign sclk_rise =  sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] &  sclk_sync[2];

  assign ifc.recv_rdy = ~tx_buf_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= 3'b111;
      sclk_sync <= 3'b000;
      mosi_sync <= 3'b000;
    end else begin
      cs_sync   <= {cs_sync[1:0],   ifc.spi_ifc_cs};
      sclk_sync <= {sclk_sync[1:0], ifc.spi_ifc_sclk};
      mosi_sync <= {mosi_sync[1:0], ifc.spi_ifc_mosi};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tx_buf        <= '0;
      tx_buf_val    <= 1'b0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      ifc.spi_ifc_miso <= 1'b0;
      ifc.send_val  <= 1'b0;
      ifc.send_msg  <= '0;
      ifc.overflow  <= 1'b0;
      ifc.underflow <= 1'b0;
    end else begin
      ifc.overflow  <= 1'b0;
      ifc.underflow <= 1'b0;

      // Default TX buffer capture; a bypass on cs_fall below overrides it.
      if (ifc.recv_val && !tx_buf_val) begin
        tx_buf     <= ifc.recv_msg;
        tx_buf_val <= 1'b1;
      end

      if (ifc.send_val && ifc.send_rdy) begin
        ifc.send_val <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ACTIVE;
            bit_cnt <= '0;
            // MISO is loaded together with the shifter so the MSB is on the
            // pin well before the master's first sampling edge.
            if (tx_buf_val) begin
              tx_shift         <= tx_buf;
              ifc.spi_ifc_miso <= tx_buf[nbits-1];
              tx_buf_val       <= 1'b0;
            end else if (ifc.recv_val) begin
              // Same-cycle offer goes straight to the shifter; buffer stays empty.
              tx_shift         <= ifc.recv_msg;
              ifc.spi_ifc_miso <= ifc.recv_msg[nbits-1];
              tx_buf_val       <= 1'b0;
            end else begin
              tx_shift         <= '0;
              ifc.spi_ifc_miso <= 1'b0;
              ifc.underflow    <= 1'b1;
            end
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            // A sclk edge coinciding with cs_rise is deliberately dropped.
            state <= IDLE;
            if (bit_cnt == logBitsN'(nbits)) begin
              // A handshake completing this cycle frees the register in time.
              if (!ifc.send_val || ifc.send_rdy) begin
                ifc.send_msg <= rx_shift;
                ifc.send_val <= 1'b1;
              end else begin
                ifc.overflow <= 1'b1;
              end
            end
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[nbits-2:0], mosi_sync[2]};
              // Saturate one past nbits so long frames never alias to nbits.
              if (bit_cnt != logBitsN'(nbits + 1)) begin
                bit_cnt <= bit_cnt + logBitsN'(1);
              end
            end
            if (sclk_fall) begin
              tx_shift         <= {tx_shift[nbits-2:0], 1'b0};
              ifc.spi_ifc_miso <= tx_shift[nbits-2];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_minion.sv
// Randomised bench for spi_minion: a frame-level model predicts the received
// words, MISO bitstream and overflow/underflow counts, and a per-cycle monitor
// checks reset values, delivered words and held-word stability.
module tb_spi_minion;
  localparam int NB = 34;

  logic clk = 1'b0;
  logic reset;

  spi_minion_if #(.nbits(NB)) ifc ();

  spi_minion #(.nbits(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model state
  logic [NB-1:0] exp_q[$];
  bit            model_held = 1'b0;
  bit            tx_pending = 1'b0;
  logic [NB-1:0] tx_word    = '0;
  int            ov_cnt = 0;
  int            uf_cnt = 0;
  bit            sv_seen = 1'b0;
  logic [NB-1:0] held_msg = '0;
  logic [NB-1:0] last_msg = '0;
  logic [NB-1:0] miso_word = '0;

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic logic [NB-1:0] rnd_word();
    logic [NB-1:0] r;
    r = NB'({$urandom(), $urandom()});
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor
  always @(negedge clk) begin
    if (reset) begin
      chk(ifc.spi_ifc_miso == 1'b0, "rst_miso", 64'(ifc.spi_ifc_miso), 0);
      chk(ifc.recv_rdy == 1'b1, "rst_recv_rdy", 64'(ifc.recv_rdy), 1);
      chk(ifc.send_val == 1'b0, "rst_send_val", 64'(ifc.send_val), 0);
      chk(ifc.send_msg == '0, "rst_send_msg", 64'(ifc.send_msg), 0);
      chk(ifc.overflow == 1'b0, "rst_overflow", 64'(ifc.overflow), 0);
      chk(ifc.underflow == 1'b0, "rst_underflow", 64'(ifc.underflow), 0);
      sv_seen = 1'b0;
    end else begin
      if (ifc.overflow)  ov_cnt++;
      if (ifc.underflow) uf_cnt++;
      if (ifc.send_val && sv_seen) begin
        chk(ifc.send_msg == held_msg, "held_msg_stable", 64'(ifc.send_msg), 64'(held_msg));
      end
      if (ifc.send_val && !sv_seen) begin
        sv_seen  = 1'b1;
        held_msg = ifc.send_msg;
        last_msg = ifc.send_msg;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_word", 64'(ifc.send_msg), 0);
        end else begin
          logic [NB-1:0] e;
          e = exp_q.pop_front();
          chk(ifc.send_msg == e, "send_msg", 64'(ifc.send_msg), 64'(e));
        end
      end
      if (!ifc.send_val) sv_seen = 1'b0;
    end
  end

  task automatic preload(input logic [NB-1:0] w);
    ifc.recv_msg = w;
    ifc.recv_val = 1'b1;
    for (int k = 0; k < 20 && !ifc.recv_rdy; k++) cyc(1);
    if (!ifc.recv_rdy) chk(1'b0, "preload_timeout", 64'(ifc.recv_rdy), 1);
    cyc(1);
    ifc.recv_val = 1'b0;
    tx_pending   = 1'b1;
    tx_word      = w;
    chk(ifc.recv_rdy == 1'b0, "preload_buffer_full", 64'(ifc.recv_rdy), 0);
  endtask

  task automatic consume();
    ifc.send_rdy = 1'b1;
    cyc(3);
    model_held = 1'b0;
    chk(ifc.send_val == 1'b0, "send_val_cleared", 64'(ifc.send_val), 0);
  endtask

  // One CS-low frame of nb sclk pulses; abort_at >= 0 resets the DUT at that bit.
  task automatic frame(input logic [NB-1:0] w, input int nb, input bit byp,
                       input logic [NB-1:0] bw, input int abort_at);
    logic [NB-1:0] exp_tx;
    bit            exp_uf;
    bit            exp_ov;
    bit            mb[0:63];
    int            ov0, uf0, half, nbad;
    ov0    = ov_cnt;
    uf0    = uf_cnt;
    exp_ov = 1'b0;
    if (tx_pending) begin
      exp_tx = tx_word; exp_uf = 1'b0; tx_pending = 1'b0;
    end else if (byp) begin
      exp_tx = bw; exp_uf = 1'b0;
    end else begin
      exp_tx = '0; exp_uf = 1'b1;
    end
    half = int'($urandom_range(4, 6));

    ifc.spi_ifc_cs = 1'b0;
    if (byp && exp_uf == 1'b0 && exp_tx == bw) begin
      // Offer the word exactly on the cycle the DUT acts on cs_fall.
      cyc(2);
      ifc.recv_msg = bw;
      ifc.recv_val = 1'b1;
      chk(ifc.recv_rdy == 1'b1, "bypass_rdy_before", 64'(ifc.recv_rdy), 1);
      cyc(1);
      ifc.recv_val = 1'b0;
      chk(ifc.recv_rdy == 1'b1, "bypass_rdy_after", 64'(ifc.recv_rdy), 1);
      chk(ifc.underflow == 1'b0, "bypass_no_underflow", 64'(ifc.underflow), 0);
      cyc(2);
    end else begin
      cyc(3);
      chk(ifc.underflow == exp_uf, "underflow_at_3clk", 64'(ifc.underflow), 64'(exp_uf));
      cyc(2);
    end

    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        ifc.spi_ifc_cs   = 1'b1;
        ifc.spi_ifc_sclk = 1'b0;
        ifc.spi_ifc_mosi = 1'b0;
        cyc(3);
        reset = 1'b0;
        tx_pending = 1'b0;
        model_held = 1'b0;
        exp_q.delete();
        cyc(10);
        chk(ifc.send_val == 1'b0, "abort_no_word", 64'(ifc.send_val), 0);
        chk(ov_cnt == ov0, "abort_no_overflow", 64'(ov_cnt - ov0), 0);
        chk(uf_cnt == uf0, "abort_no_underflow", 64'(uf_cnt - uf0), 0);
        return;
      end
      if (i < NB) ifc.spi_ifc_mosi = w[NB-1-i];
      else        ifc.spi_ifc_mosi = 1'b0;
      cyc(half);
      mb[i] = ifc.spi_ifc_miso;
      ifc.spi_ifc_sclk = 1'b1;
      cyc(half);
      ifc.spi_ifc_sclk = 1'b0;
    end

    if (nb == NB) begin
      if (model_held && !ifc.send_rdy) exp_ov = 1'b1;
      else begin
        exp_q.push_back(w);
        model_held = !ifc.send_rdy;
      end
    end
    cyc(half);
    ifc.spi_ifc_cs = 1'b1;
    cyc(10);

    chk(ov_cnt - ov0 == int'(exp_ov), "overflow_count", 64'(ov_cnt - ov0), 64'(exp_ov));
    chk(uf_cnt - uf0 == int'(exp_uf), "underflow_count", 64'(uf_cnt - uf0), 64'(exp_uf));
    chk(exp_q.size() == 0, "word_delivered", 64'(exp_q.size()), 0);
    nbad = 0;
    miso_word = '0;
    for (int i = 0; i < nb; i++) begin
      logic eb;
      eb = (i < NB) ? exp_tx[NB-1-i] : 1'b0;
      if (mb[i] !== eb) nbad++;
      if (i < NB) miso_word[NB-1-i] = mb[i];
    end
    chk(nbad == 0, "miso_stream", 64'(miso_word), 64'(exp_tx));
  endtask

  initial begin
    int ovs, nb;
    bit byp;
    reset = 1'b1;
    ifc.spi_ifc_cs   = 1'b1;
    ifc.spi_ifc_sclk = 1'b0;
    ifc.spi_ifc_mosi = 1'b0;
    ifc.recv_val     = 1'b0;
    ifc.recv_msg     = '0;
    ifc.send_rdy     = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(3);

    // Normal loopback
    preload(34'h2_DEAD_BEEF);
    frame(34'h1_2345_6789, NB, 1'b0, '0, -1);
    chk(last_msg == 34'h1_2345_6789, "loopback_rx_literal", 64'(last_msg), 64'h1_2345_6789);
    chk(miso_word == 34'h2_DEAD_BEEF, "loopback_tx_literal", 64'(miso_word), 64'h2_DEAD_BEEF);
    chk(ifc.recv_rdy == 1'b1, "loopback_rdy_back", 64'(ifc.recv_rdy), 1);

    // Back-pressure
    ifc.send_rdy = 1'b0;
    cyc(2);
    ovs = ov_cnt;
    frame(34'h2_AAAA_AAAA, NB, 1'b0, '0, -1);
    frame(34'h1_5555_5555, NB, 1'b0, '0, -1);
    chk(ov_cnt - ovs == 1, "backpressure_one_overflow", 64'(ov_cnt - ovs), 1);
    chk(ifc.send_msg == 34'h2_AAAA_AAAA, "backpressure_first_kept",
        64'(ifc.send_msg), 64'h2_AAAA_AAAA);
    consume();
    cyc(20);
    chk(ifc.send_val == 1'b0, "backpressure_no_second", 64'(ifc.send_val), 0);

    // Underflow
    frame(rnd_word(), NB, 1'b0, '0, -1);
    chk(miso_word == '0, "underflow_miso_zero", 64'(miso_word), 0);

    // Bypass
    frame(rnd_word(), NB, 1'b1, rnd_word(), -1);
    chk(ifc.recv_rdy == 1'b1, "bypass_rdy_stays", 64'(ifc.recv_rdy), 1);

    // Bad lengths, then a good frame
    frame(rnd_word(), NB - 1, 1'b0, '0, -1);
    frame(rnd_word(), NB + 1, 1'b0, '0, -1);
    frame(rnd_word(), NB, 1'b0, '0, -1);

    // Mid-frame reset
    preload(rnd_word());
    frame(rnd_word(), NB, 1'b0, '0, 17);
    frame(rnd_word(), NB, 1'b0, '0, -1);

    // Randomised frames
    for (int f = 0; f < 10; f++) begin
      ifc.send_rdy = 1'($urandom_range(0, 1));
      cyc(3);
      if (ifc.send_rdy) model_held = 1'b0;
      if ($urandom_range(0, 1) == 1 && !tx_pending) preload(rnd_word());
      case ($urandom_range(0, 3))
        0:       nb = NB - 1;
        1:       nb = NB + 1;
        default: nb = NB;
      endcase
      byp = !tx_pending && ($urandom_range(0, 2) == 0);
      frame(rnd_word(), nb, byp, rnd_word(), -1);
    end
    consume();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
